// File: rtl/spm_mem_pkg.sv
// Shared widths, FSM state encoding and wait-counter helper for the scratchpad memory responder.
package spm_mem_pkg;

    localparam int ADDR_W = 8;
    localparam int WORD_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // The counter is preloaded with ws-1 so that WAIT lasts exactly ws cycles.
    function automatic logic [CNT_W-1:0] wait_init(input int ws);
        if (ws > 0) begin
            return CNT_W'(ws - 1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/spm_mem_array.sv
// 256x8 register array: one synchronous write port plus a combinational read port
// that the responder samples into its registered read data.
module spm_mem_array
    import spm_mem_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Contents are deliberately left out of reset so a program survives a processor reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/spm_mem_responder.sv
// Scratchpad memory responder: wait-stated single-access FSM in front of a 256x8 array.
// Optional boot loader (LOAD state, ld_ptr) is built only when SPM_LOADER_EN is defined.
module spm_mem_responder
    import spm_mem_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] data_in,
    input  logic              req,
    input  logic              write,
    output logic [WORD_W-1:0] mem_word,
    output logic              ready,
    output logic              busy,
    input  logic              ld_valid,
    input  logic [WORD_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_done
);

    localparam logic [CNT_W-1:0] WAIT_INIT = wait_init(WAIT_STATES);

`ifdef SPM_LOADER_EN
    localparam state_t RESET_STATE = LOAD;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t            state;
    state_t            next_state;
    logic              accept;
    logic              enter_resp;
    logic              commit;
    logic [ADDR_W-1:0] cap_addr;
    logic [WORD_W-1:0] cap_data;
    logic              cap_write;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] acc_addr;
    logic [WORD_W-1:0] acc_data;
    logic              acc_write;
    logic              load_write;
    logic              load_finish;
    logic [ADDR_W-1:0] load_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] rd_data;

`ifdef SPM_LOADER_EN
    logic [ADDR_W-1:0] ld_ptr;
    logic              ld_done_q;

    // Loader writes win over processor requests while in LOAD.
    assign load_write  = (state == LOAD) && ld_valid && !rst;
    assign load_finish = load_write && (ld_last || (ld_ptr == '1));
    assign load_addr   = ld_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_ptr    <= '0;
            ld_done_q <= 1'b0;
        end else begin
            if (load_write) begin
                ld_ptr <= ld_ptr + 8'd1;
            end
            if (load_finish) begin
                ld_done_q <= 1'b1;
            end
        end
    end

    assign ld_done = ld_done_q;
`else
    logic ld_unused;

    assign ld_unused   = ^{ld_valid, ld_data, ld_last};
    assign load_write  = 1'b0;
    assign load_finish = 1'b0;
    assign load_addr   = '0;
    assign ld_done     = 1'b1;
`endif

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            LOAD: begin
                if (load_finish) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    next_state = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = RESET_STATE;
            end
        endcase
    end

    // With zero wait states the accept edge is also the RESP entry edge, so the
    // live inputs stand in for the not-yet-captured registers.
    assign acc_addr  = (state == IDLE) ? addr    : cap_addr;
    assign acc_data  = (state == IDLE) ? data_in : cap_data;
    assign acc_write = (state == IDLE) ? write   : cap_write;

    assign enter_resp = (next_state == RESP) && (state != RESP);
    assign commit     = enter_resp && acc_write && !rst;

    assign mem_we    = load_write || commit;
    assign mem_waddr = load_write ? load_addr : acc_addr;
    assign mem_wdata = load_write ? ld_data   : acc_data;

    spm_mem_array u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (acc_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RESET_STATE;
            cap_addr  <= '0;
            cap_data  <= '0;
            cap_write <= 1'b0;
            wait_cnt  <= '0;
            mem_word  <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                cap_addr  <= addr;
                cap_data  <= data_in;
                cap_write <= write;
                wait_cnt  <= WAIT_INIT;
            end else if ((state == WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (enter_resp && !acc_write) begin
                mem_word <= rd_data;
            end
        end
    end

    assign ready = (state == RESP);
    assign busy  = (state != IDLE);

endmodule

// File: doc/spm_mem_responder.md
SPM_MEM_RESPONDER -- requirements
Module: spm_mem_responder

Interface
REQ-001 Parameter WAIT_STATES, default 1: extra cycles inserted before each access completes; legal range 0..15.
REQ-002 clk  input  1  single clock; every flop updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 addr  input  8  word address, taken from the processor address register.
REQ-005 data_in  input  8  write data, driven from Bus_1.
REQ-006 req  input  1  access request, level-sampled.
REQ-007 write  input  1  access type: 1 = write, 0 = read.
REQ-008 mem_word  output  8  registered read data, routed to Bus_2.
REQ-009 ready  output  1  one-cycle completion pulse.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 ld_valid  input  1  program-loader data strobe.
REQ-012 ld_data  input  8  program-loader data word.
REQ-013 ld_last  input  1  marks the final loader word.
REQ-014 ld_done  output  1  loader finished; processor accesses are enabled.

Function
REQ-015 The block SHALL implement the FSM states LOAD, IDLE, WAIT and RESP, and busy SHALL equal (state != IDLE).
REQ-016 On reset release the FSM SHALL enter LOAD, and SHALL stay there until the load completes.
REQ-017 In LOAD, each cycle with ld_valid=1 SHALL write ld_data to mem[ld_ptr] and then increment the 8-bit ld_ptr, which starts at 0.
REQ-018 The load SHALL complete on a ld_valid&ld_last write, or on the 256th write (ld_ptr wraps 255->0); completion SHALL set ld_done=1 (sticky) and move the FSM to IDLE.
REQ-019 In LOAD, req SHALL be ignored, and ready SHALL stay 0.
REQ-020 ld_last without ld_valid SHALL have no effect.
REQ-021 In IDLE, req=1 at an edge SHALL accept the access, capturing addr, write and data_in into internal registers.
REQ-022 After an accept, the FSM SHALL go to WAIT if WAIT_STATES>0, or directly to RESP if WAIT_STATES=0.
REQ-023 WAIT SHALL last exactly WAIT_STATES cycles, timed by a 4-bit down-counter, and SHALL then go to RESP.
REQ-024 On the edge entering RESP, a read SHALL load mem_word <= mem[captured addr], and a write SHALL commit mem[captured addr] <= captured data.
REQ-025 ready SHALL be 1 for exactly the RESP cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-026 The total latency from the accept edge to ready high SHALL be WAIT_STATES+1 cycles.
REQ-027 mem_word SHALL hold its value until the next read completes; a write SHALL NOT change mem_word.
REQ-028 Changes to req, addr, write or data_in while busy SHALL be ignored.
REQ-029 A req held high through RESP SHALL be accepted again in the following IDLE cycle.
REQ-030 A read that follows a write to the same address SHALL return the newly written data.
REQ-031 In LOAD, ld_valid=1 and req=1 in the same cycle SHALL perform the loader write only.

Reset
REQ-032 Reset SHALL force: state=LOAD, mem_word=0, ready=0, ld_done=0, ld_ptr=0 and the wait counter=0.
REQ-033 busy SHALL be 1 during reset, because the FSM is in LOAD.
REQ-034 The memory contents SHALL NOT be reset.
REQ-035 A reset asserted in WAIT or RESP SHALL abort the access; a write not yet committed SHALL NOT reach the memory.

Configuration
REQ-036 With macro SPM_LOADER_EN defined, the loader SHALL behave as in REQ-016 to REQ-020 and REQ-031.
REQ-037 With SPM_LOADER_EN undefined, the LOAD state and ld_ptr SHALL be removed, ld_* inputs SHALL be ignored, ld_done SHALL be tied to 1, and the reset state SHALL be IDLE.

Structure
REQ-038 Package spm_mem_pkg SHALL hold ADDR_W=8, WORD_W=8 and the FSM state enum (LOAD, IDLE, WAIT, RESP).
REQ-039 Sub-module spm_mem_array SHALL provide a 256x8 register array with one synchronous write port and a read port used by the registered read.

Verification
REQ-040 Load: ld_data 0x51,0x0C,0xF0, last on 0xF0 -> mem[0..2] = 0x51,0x0C,0xF0; ld_done=1 one cycle after the last write; busy falls with it.
REQ-041 Read, WAIT_STATES=1: req=1, write=0, addr=0x01 -> ready pulses exactly 2 cycles after accept; mem_word=0x0C.
REQ-042 Write then read, WAIT_STATES=0: write 0xA5 to 0x80, then read 0x80 -> each ready 1 cycle after its accept; mem_word=0xA5; mem_word unchanged by the write.
REQ-043 Busy masking: during a WAIT_STATES=3 read of 0x02, change addr to 0x00 and pulse req -> single ready; mem_word=0xF0.
REQ-044 Wrap: 256 ld_valid writes with no ld_last -> ld_done=1 after write 256; ld_ptr=0; a req issued during LOAD produces no ready.
REQ-045 Reset mid-write: assert rst during WAIT of a write of 0x33 to 0x10 -> mem[0x10] unchanged; outputs at reset values; FSM in LOAD, or IDLE without SPM_LOADER_EN.
